// File: rtl/reduce_accum_if.sv
// Stream interface for reduce_accum: word input handshake plus frame result handshake.
// Optional o_ovf signal present when REDUCE_ACCUM_SAT_CNT_EN is defined.
interface reduce_accum_if #(
    parameter int unsigned W     = 20,
    parameter int unsigned CNT_W = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [W-1:0]     i_data;
    logic             i_last;
    logic             o_valid;
    logic             i_ready;
    logic             o_and;
    logic             o_or;
    logic             o_xor;
    logic [CNT_W-1:0] o_count;
`ifdef REDUCE_ACCUM_SAT_CNT_EN
    logic             o_ovf;

    // Design side
    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_and, o_or, o_xor, o_count, o_ovf
    );

    // Environment side
    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_and, o_or, o_xor, o_count, o_ovf
    );
`else
    // Design side
    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_and, o_or, o_xor, o_count
    );

    // Environment side
    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_and, o_or, o_xor, o_count
    );
`endif
endinterface

// File: rtl/reduce_accum.sv
// reduce_accum: folds per-word AND/OR/XOR reductions over a frame and presents
// one registered result per frame on a valid/ready handshake.
// Optional macro REDUCE_ACCUM_SAT_CNT_EN: saturating word counter plus sticky o_ovf.
module reduce_accum #(
    parameter int unsigned W     = 20,
    parameter int unsigned CNT_W = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    reduce_accum_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state_q, state_d;
    logic             in_fire, out_fire, last_fire;
    logic             w_and, w_or, w_xor;
    logic             and_acc, or_acc, xor_acc;
    logic [CNT_W-1:0] cnt_acc, cnt_inc;
    logic             res_and, res_or, res_xor;
    logic [CNT_W-1:0] res_count;
`ifdef REDUCE_ACCUM_SAT_CNT_EN
    logic             ovf_acc, ovf_inc, res_ovf;
`endif

    // Handshake decode; o_ready is the only input-to-output combinational path
    assign bus.o_valid = (state_q == HOLD);
    assign bus.o_ready = (state_q == ACCUM) | bus.i_ready;
    assign in_fire     = bus.i_valid & bus.o_ready;
    assign out_fire    = bus.o_valid & bus.i_ready;
    assign last_fire   = in_fire & bus.i_last;

    // Per-word reductions
    assign w_and = &bus.i_data;
    assign w_or  = |bus.i_data;
    assign w_xor = ^bus.i_data;

`ifdef REDUCE_ACCUM_SAT_CNT_EN
    // Saturating count; flag any increment attempted at the maximum
    always_comb begin
        cnt_inc = cnt_acc + CNT_W'(1);
        ovf_inc = ovf_acc;
        if (cnt_acc == {CNT_W{1'b1}}) begin
            cnt_inc = cnt_acc;
            ovf_inc = 1'b1;
        end
    end
`else
    // Wrapping count
    always_comb begin
        cnt_inc = cnt_acc + CNT_W'(1);
    end
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (last_fire) state_d = HOLD;
            HOLD:  if (out_fire && !last_fire) state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    // Frame accumulators: fold on non-last accepts, return to identity at frame end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            and_acc <= 1'b1;
            or_acc  <= 1'b0;
            xor_acc <= 1'b0;
            cnt_acc <= '0;
`ifdef REDUCE_ACCUM_SAT_CNT_EN
            ovf_acc <= 1'b0;
`endif
        end else if (in_fire) begin
            if (bus.i_last) begin
                and_acc <= 1'b1;
                or_acc  <= 1'b0;
                xor_acc <= 1'b0;
                cnt_acc <= '0;
`ifdef REDUCE_ACCUM_SAT_CNT_EN
                ovf_acc <= 1'b0;
`endif
            end else begin
                and_acc <= and_acc & w_and;
                or_acc  <= or_acc | w_or;
                xor_acc <= xor_acc ^ w_xor;
                cnt_acc <= cnt_inc;
`ifdef REDUCE_ACCUM_SAT_CNT_EN
                ovf_acc <= ovf_inc;
`endif
            end
        end
    end

    // Result registers load the folded values including the last word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            res_and   <= 1'b0;
            res_or    <= 1'b0;
            res_xor   <= 1'b0;
            res_count <= '0;
`ifdef REDUCE_ACCUM_SAT_CNT_EN
            res_ovf   <= 1'b0;
`endif
        end else if (last_fire) begin
            res_and   <= and_acc & w_and;
            res_or    <= or_acc | w_or;
            res_xor   <= xor_acc ^ w_xor;
            res_count <= cnt_inc;
`ifdef REDUCE_ACCUM_SAT_CNT_EN
            res_ovf   <= ovf_inc;
`endif
        end
    end

    assign bus.o_and   = res_and;
    assign bus.o_or    = res_or;
    assign bus.o_xor   = res_xor;
    assign bus.o_count = res_count;
`ifdef REDUCE_ACCUM_SAT_CNT_EN
    assign bus.o_ovf   = res_ovf;
`endif

endmodule

// File: tb/tb_reduce_accum.sv
// Directed bench for reduce_accum with an expected-result scoreboard queue.
module tb_reduce_accum;
    localparam int unsigned W     = 20;
    localparam int unsigned CNT_W = 2;

    typedef struct packed {
        logic             a;
        logic             o;
        logic             x;
        logic [CNT_W-1:0] c;
        logic             v;
    } res_t;

    logic i_clk = 1'b0;
    logic i_rst;
    int   total = 0;
    int   bad   = 0;
    logic m_valid;
    res_t cur;
    res_t q[$];

    reduce_accum_if #(.W(W), .CNT_W(CNT_W)) bus ();

    reduce_accum #(.W(W), .CNT_W(CNT_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic a, input logic o, input logic x,
                        input logic [CNT_W-1:0] c, input logic v);
        res_t r;
        r.a = a; r.o = o; r.x = x; r.c = c; r.v = v;
        q.push_back(r);
    endtask

    task automatic check_outs();
        chk("o_valid", 32'(bus.o_valid), 32'(m_valid));
        chk("o_and",   32'(bus.o_and),   32'(cur.a));
        chk("o_or",    32'(bus.o_or),    32'(cur.o));
        chk("o_xor",   32'(bus.o_xor),   32'(cur.x));
        chk("o_count", 32'(bus.o_count), 32'(cur.c));
`ifdef REDUCE_ACCUM_SAT_CNT_EN
        chk("o_ovf",   32'(bus.o_ovf),   32'(cur.v));
`endif
    endtask

    // Entered and left on a falling edge
    task automatic do_reset();
        bus.i_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        m_valid = 1'b0;
        cur = '0;
        check_outs();
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // One clock of stimulus; entered and left on a falling edge
    task automatic step(input logic v, input logic [W-1:0] d, input logic l, input logic r);
        logic exp_rdy, fire;
        bus.i_valid = v;
        bus.i_data  = d;
        bus.i_last  = l;
        bus.i_ready = r;
        #1;
        exp_rdy = !m_valid || r;
        chk("o_ready", 32'(bus.o_ready), 32'(exp_rdy));
        fire = v && exp_rdy;
        @(posedge i_clk);
        #1;
        if (fire && l) begin
            total++;
            assert (q.size() > 0) else begin
                bad++;
                $error("FAIL scoreboard_empty observed=%0d expected=%0d", q.size(), 1);
            end
            if (q.size() > 0) cur = q.pop_front();
            m_valid = 1'b1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        check_outs();
        @(negedge i_clk);
    endtask

    initial begin
        i_rst       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b0;
        m_valid     = 1'b0;
        cur         = '0;
        @(negedge i_clk);
        do_reset();

        // Single all-ones word frame, then consume
        push(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        step(1'b1, 20'hFFFFF, 1'b1, 1'b1);
        step(1'b0, 20'h00000, 1'b0, 1'b1);

        // Three-word frame, result one cycle after the last accept
        push(1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
        step(1'b1, 20'h00001, 1'b0, 1'b0);
        step(1'b1, 20'h00000, 1'b0, 1'b0);
        step(1'b1, 20'h00003, 1'b1, 1'b0);

        // Hold with a pending word for 4 cycles, then release: consume and accept together
        for (int i = 0; i < 4; i++) step(1'b1, 20'h00002, 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        step(1'b1, 20'h00002, 1'b1, 1'b1);

        // Back-to-back single-word frames, no bubble
        push(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        step(1'b1, 20'h00007, 1'b1, 1'b1);
        push(1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        step(1'b1, 20'h00000, 1'b1, 1'b1);
        push(1'b1, 1'b1, 1'b0, 2'd1, 1'b0);
        step(1'b1, 20'hFFFFF, 1'b1, 1'b1);
        step(1'b0, 20'h00000, 1'b0, 1'b1);

        // Reset mid-frame discards the partial frame
        step(1'b1, 20'hFFFFF, 1'b0, 1'b1);
        step(1'b1, 20'h00005, 1'b0, 1'b1);
        do_reset();
        push(1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        step(1'b1, 20'h00000, 1'b1, 1'b1);
        step(1'b0, 20'h00000, 1'b0, 1'b1);

        // Five-word frame through a 2-bit counter
`ifdef REDUCE_ACCUM_SAT_CNT_EN
        push(1'b0, 1'b0, 1'b0, 2'd3, 1'b1);
`else
        push(1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
`endif
        for (int i = 0; i < 4; i++) step(1'b1, 20'h00000, 1'b0, 1'b1);
        step(1'b1, 20'h00000, 1'b1, 1'b1);
        push(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        step(1'b1, 20'h00001, 1'b1, 1'b1);
        step(1'b0, 20'h00000, 1'b0, 1'b1);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reduce_accum.md
Name: reduce_accum

Overview:
- Streaming frame reducer that sits directly downstream of the combinational reduction stage.
- Accepts W-bit words over a valid/ready handshake and folds per-word AND/OR/XOR reductions across a frame terminated by i_last.
- Presents one registered result per frame (frame-wide AND, OR, XOR, word count) on an output valid/ready handshake.
- Serves as the sequential test vehicle for techmapping reductions feeding registers and handshake logic.

Parameters:
- W, 20, data word width in bits.
- CNT_W, 8, width of the frame word counter.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  block can accept a word this cycle.
- i_data  input  W  data word.
- i_last  input  1  word is the final word of its frame.
- o_valid  output  1  result registers hold an unconsumed frame result.
- i_ready  input  1  downstream accepts the result this cycle.
- o_and  output  1  AND of &word over all words of the frame.
- o_or  output  1  OR of |word over all words of the frame.
- o_xor  output  1  XOR of ^word over all words of the frame (parity of all frame bits).
- o_count  output  CNT_W  number of words in the frame, including the last word.

Behaviour:
- Reset (asynchronous, active-high):
  - o_valid=0; o_and=0, o_or=0, o_xor=0, o_count=0.
  - Accumulators to identity: and_acc=1, or_acc=0, xor_acc=0, cnt_acc=0.
  - Reset mid-frame discards the partial frame; the next accepted word starts a new frame.
- Handshakes:
  - o_ready = !o_valid | i_ready. This is the only combinational input-to-output path.
  - Input accept: in_fire = i_valid & o_ready.
  - Output consume: out_fire = o_valid & i_ready.
- Accumulation, on in_fire with i_last=0:
  - and_acc &= &i_data; or_acc |= |i_data; xor_acc ^= ^i_data; cnt_acc += 1.
- Frame end, on in_fire with i_last=1:
  - Result registers load the folded values including the current word: o_and = and_acc & (&i_data), and likewise for o_or, o_xor, and o_count = cnt_acc+1.
  - o_valid=1 the next cycle.
  - Accumulators return to identity.
  - Latency: result visible 1 cycle after the last word is accepted.
- Hold:
  - While o_valid=1 and i_ready=0: o_ready=0, no input accepted, all result outputs stable.
- Consume:
  - out_fire without a simultaneous last-word in_fire: o_valid clears next cycle; result outputs retain their values.
- Simultaneous consume and last-word accept:
  - o_valid stays 1 and the new result replaces the old one; no bubble.
  - Single-word frames sustain one result per cycle while i_ready=1.
- Inputs while o_ready=0: ignored and do not affect accumulators.
- Empty frames do not exist; every frame has count >= 1.
- Counter wrap, default build: cnt_acc wraps modulo 2^CNT_W.
- States:
  - ACCUM (o_valid=0): accepts freely.
  - HOLD (o_valid=1): accepts only when i_ready=1.
  - ACCUM->HOLD on last-word in_fire.
  - HOLD->ACCUM on out_fire without last-word in_fire.
  - HOLD->HOLD on out_fire with last-word in_fire, or on no out_fire.

Optional Feature:
- Macro: REDUCE_ACCUM_SAT_CNT_EN.
- Defined:
  - Adds port o_ovf (output, 1).
  - cnt_acc saturates at 2^CNT_W-1 instead of wrapping.
  - A sticky per-frame overflow bit sets on any increment attempted at max.
  - o_ovf loads with the result, resets to 0 and clears with the accumulators.
- Undefined:
  - No o_ovf port; count wraps.

Test Plan:
- Reset, then single-word frame i_data=20'hFFFFF, i_last=1, i_ready=1 -> next cycle o_valid=1, o_and=1, o_or=1, o_xor=0, o_count=1; cycle after, o_valid=0.
- Frame 20'h00001, 20'h00000, 20'h00003(last) -> o_and=0, o_or=1, o_xor=1, o_count=3, exactly 1 cycle after the third accept.
- Result held with i_ready=0 for 4 cycles while i_valid=1 -> o_ready=0, outputs stable, no words consumed. Raise i_ready -> the pending word is accepted that same cycle.
- Back-to-back single-word frames 20'h00007, 20'h00000, 20'hFFFFF with i_ready=1 -> o_valid high 3 consecutive cycles with xor=1,0,0, or=1,0,1, and=0,0,1.
- Two non-last words accepted, then i_rst pulsed mid-frame, then frame 20'h00000(last) -> o_and=0, o_or=0, o_xor=0, o_count=1.
- CNT_W=2, frame of 5 words -> macro undefined: o_count=1. Macro defined: o_count=3, o_ovf=1; following 1-word frame gives o_ovf=0.
